igr_arb_csr_regs: RTL and testbench

Parametrised CSR block for the PTP bridge ingress arbiter. It serves NUM_INTF packed 4-bit priority fields, a per-interface enable mask, and per-interface saturating grant counters over one AVMM slave port. It sits between the bridge AVMM interconnect and the ingress arbiter core. It adds range checking, byte-enable writes, counter clear, and optional atomic shadow/commit of arbitration config.

---
 rtl/ptp_bridge_pkg.sv | 45 ++++
 rtl/igr_arb_grant_cnt.sv | 35 +++
 rtl/igr_arb_csr_regs.sv | 172 +++++++++++++++++
 tb/tb_igr_arb_csr_regs.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_bridge_pkg.sv
// Shared types and CSR layout helpers for the PTP bridge ingress arbiter.
// The CSR map is derived from the interface count.
package ptp_bridge_pkg;

    localparam int unsigned PRIO_W = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned CSR_DW = 32;

    typedef logic [PRIO_W-1:0] prio_t;

    typedef enum logic [2:0] {
        CSR_NONE,
        CSR_PRIO,
        CSR_ENABLE,
        CSR_CTRL,
        CSR_STATUS,
        CSR_CNT
    } csr_sel_e;

    // Eight 4-bit priority nibbles per 32-bit PRIO word.
    function automatic int unsigned csr_prio_words(input int unsigned n);
        return (n + 7) / 8;
    endfunction

    function automatic int unsigned csr_enable_off(input int unsigned n);
        return csr_prio_words(n);
    endfunction

    function automatic int unsigned csr_ctrl_off(input int unsigned n);
        return csr_prio_words(n) + 1;
    endfunction

    function automatic int unsigned csr_status_off(input int unsigned n);
        return csr_prio_words(n) + 2;
    endfunction

    function automatic int unsigned csr_cnt_off(input int unsigned n);
        return csr_prio_words(n) + 3;
    endfunction

    function automatic int unsigned csr_window(input int unsigned n);
        return csr_prio_words(n) + 3 + n;
    endfunction

endpackage

// File: rtl/igr_arb_grant_cnt.sv
// One 32-bit saturating grant counter with synchronous clear.
// Clear takes priority over increment.
module igr_arb_grant_cnt
    import ptp_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_nxt = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/igr_arb_csr_regs.sv
// AVMM CSR block for the ingress arbiter: priorities, enable mask, grant counters.
// Define IGR_ARB_CSR_SHADOW_EN for shadowed config with atomic COMMIT on arb_idle.
module igr_arb_csr_regs
    import ptp_bridge_pkg::*;
#(
    parameter int unsigned          BASE_ADDR  = 'h0,
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   NUM_INTF   = 4,
    parameter prio_t                PRIO_RST   = 4'h0,
    parameter logic [NUM_INTF-1:0]  EN_RST     = '1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          avmm_address,
    input  logic                           avmm_read,
    input  logic                           avmm_write,
    input  logic [31:0]                    avmm_writedata,
    input  logic [3:0]                     avmm_byteenable,
    output logic [31:0]                    avmm_readdata,
    output logic                           avmm_readdata_valid,
    input  logic                           arb_grant_valid,
    input  logic [NUM_INTF-1:0]            arb_grant,
    input  logic                           arb_idle,
    output logic [NUM_INTF-1:0][PRIO_W-1:0] cfg_priority,
    output logic [NUM_INTF-1:0]            cfg_enable
);

    if (DATA_WIDTH != 32) begin : g_bad_dw
        $error("igr_arb_csr_regs: DATA_WIDTH must be 32");
    end
    if (NUM_INTF < 1 || NUM_INTF > 32) begin : g_bad_num
        $error("igr_arb_csr_regs: NUM_INTF must be 1..32");
    end

    localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] OFF_EN     = ADDR_WIDTH'(csr_enable_off(NUM_INTF));
    localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(csr_ctrl_off(NUM_INTF));
    localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(csr_status_off(NUM_INTF));
    localparam logic [ADDR_WIDTH-1:0] OFF_CNT    = ADDR_WIDTH'(csr_cnt_off(NUM_INTF));
    localparam logic [ADDR_WIDTH-1:0] WIN        = ADDR_WIDTH'(csr_window(NUM_INTF));

    csr_sel_e                        sel;
    logic [ADDR_WIDTH-1:0]           off;
    logic [ADDR_WIDTH-1:0]           idx;
    logic                            wr_prio, wr_en, cnt_clr, commit_req;
    logic                            commit_pending;
    logic [NUM_INTF-1:0][PRIO_W-1:0] prio_prog, prio_nxt;
    logic [NUM_INTF-1:0]             en_prog, en_nxt;
    logic [CNT_W-1:0]                cnt_val [NUM_INTF];
    logic [CSR_DW-1:0]               prio_or [NUM_INTF+1];
    logic [CSR_DW-1:0]               cnt_or  [NUM_INTF+1];
    logic [CSR_DW-1:0]               rd_mux;
    logic                            unused_ok;

    always_comb begin
        off = avmm_address - BASE_A;
        sel = CSR_NONE;
        idx = '0;
        if ((avmm_address >= BASE_A) && (off < WIN)) begin
            if (off < OFF_EN) begin
                sel = CSR_PRIO;
                idx = off;
            end else if (off == OFF_EN) begin
                sel = CSR_ENABLE;
            end else if (off == OFF_CTRL) begin
                sel = CSR_CTRL;
            end else if (off == OFF_STATUS) begin
                sel = CSR_STATUS;
            end else begin
                sel = CSR_CNT;
                idx = off - OFF_CNT;
            end
        end
    end

    assign wr_prio    = avmm_write && (sel == CSR_PRIO);
    assign wr_en      = avmm_write && (sel == CSR_ENABLE);
    assign cnt_clr    = avmm_write && (sel == CSR_CTRL) && avmm_byteenable[0] && avmm_writedata[1];
    assign commit_req = avmm_write && (sel == CSR_CTRL) && avmm_byteenable[0] && avmm_writedata[0];

    assign prio_or[0] = '0;
    assign cnt_or[0]  = '0;

    // Per interface: byte-lane write merge, counter, and its share of the read mux.
    for (genvar g = 0; g < NUM_INTF; g++) begin : gen_cnt
        assign prio_nxt[g] = (wr_prio && (idx == ADDR_WIDTH'(g / 8)) && avmm_byteenable[(g % 8) / 2])
                             ? avmm_writedata[(g % 8) * 4 +: 4] : prio_prog[g];
        assign en_nxt[g]   = (wr_en && avmm_byteenable[g / 8]) ? avmm_writedata[g] : en_prog[g];

        igr_arb_grant_cnt u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (arb_grant_valid && arb_grant[g]),
            .clr   (cnt_clr),
            .count (cnt_val[g])
        );

        assign prio_or[g+1] = prio_or[g] | ((idx == ADDR_WIDTH'(g / 8))
                              ? (CSR_DW'(prio_prog[g]) << ((g % 8) * 4)) : '0);
        assign cnt_or[g+1]  = cnt_or[g] | ((idx == ADDR_WIDTH'(g)) ? cnt_val[g] : '0);
    end

    always_comb begin
        rd_mux = '0;
        unique case (sel)
            CSR_PRIO:   rd_mux = prio_or[NUM_INTF];
            CSR_ENABLE: rd_mux = CSR_DW'(en_prog);
            CSR_STATUS: rd_mux = CSR_DW'(commit_pending);
            CSR_CNT:    rd_mux = cnt_or[NUM_INTF];
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avmm_readdata       <= '0;
            avmm_readdata_valid <= 1'b0;
        end else begin
            avmm_readdata_valid <= avmm_read;
            avmm_readdata       <= avmm_read ? rd_mux : '0;
        end
    end

`ifdef IGR_ARB_CSR_SHADOW_EN
    logic [NUM_INTF-1:0][PRIO_W-1:0] live_prio;
    logic [NUM_INTF-1:0]             live_en;
    logic                            pending;

    // Commit copies the registered shadow, so shadow writes up to the copy edge are included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_prog <= {NUM_INTF{PRIO_RST}};
            en_prog   <= EN_RST;
            live_prio <= {NUM_INTF{PRIO_RST}};
            live_en   <= EN_RST;
            pending   <= 1'b0;
        end else begin
            prio_prog <= prio_nxt;
            en_prog   <= en_nxt;
            if (pending && arb_idle) begin
                live_prio <= prio_prog;
                live_en   <= en_prog;
                pending   <= 1'b0;
            end else if (commit_req) begin
                pending   <= 1'b1;
            end
        end
    end

    assign cfg_priority   = live_prio;
    assign cfg_enable     = live_en;
    assign commit_pending = pending;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_prog <= {NUM_INTF{PRIO_RST}};
            en_prog   <= EN_RST;
        end else begin
            prio_prog <= prio_nxt;
            en_prog   <= en_nxt;
        end
    end

    assign cfg_priority   = prio_prog;
    assign cfg_enable     = en_prog;
    assign commit_pending = 1'b0;
`endif

    assign unused_ok = ^{avmm_writedata, arb_idle, commit_req};

endmodule

// File: tb/tb_igr_arb_csr_regs.sv
// Self-checking bench for igr_arb_csr_regs: directed table, corner sequences,
// and randomized traffic against an array-based register model.
module tb_igr_arb_csr_regs;

    localparam int N    = 4;
    localparam int BASE = 0;
    localparam int PW   = (N + 7) / 8;
    localparam int WIN  = PW + 3 + N;
`ifdef IGR_ARB_CSR_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        addr;
    logic              rd, wr;
    logic [31:0]       wd;
    logic [3:0]        be;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              gv;
    logic [N-1:0]      grant;
    logic              idle;
    logic [N-1:0][3:0] cfg_prio;
    logic [N-1:0]      cfg_en;

    igr_arb_csr_regs #(
        .BASE_ADDR  (BASE),
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_INTF   (N),
        .PRIO_RST   (4'h0),
        .EN_RST     ({N{1'b1}})
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .avmm_address        (addr),
        .avmm_read           (rd),
        .avmm_write          (wr),
        .avmm_writedata      (wd),
        .avmm_byteenable     (be),
        .avmm_readdata       (rdata),
        .avmm_readdata_valid (rvalid),
        .arb_grant_valid     (gv),
        .arb_grant           (grant),
        .arb_idle            (idle),
        .cfg_priority        (cfg_prio),
        .cfg_enable          (cfg_en)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: plain arrays holding what software would see.
    logic [3:0]  m_prio_prog [N];
    logic [3:0]  m_prio_live [N];
    logic        m_en_prog   [N];
    logic        m_en_live   [N];
    logic [31:0] m_cnt       [N];
    bit          m_pend;
    logic [31:0] exp_rd;
    logic        exp_rv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_prio_prog[i] = 4'h0; m_prio_live[i] = 4'h0;
            m_en_prog[i]   = 1'b1; m_en_live[i]   = 1'b1;
            m_cnt[i]       = 32'h0;
        end
        m_pend = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int          off;
        logic [31:0] v;
        v   = 32'h0;
        off = int'(a) - BASE;
        if (off < 0 || off >= WIN) return 32'h0;
        if (off < PW) begin
            for (int j = 0; j < 8; j++)
                if (off * 8 + j < N) v = v | (32'(m_prio_prog[off * 8 + j]) << (j * 4));
        end else if (off == PW) begin
            for (int i = 0; i < N; i++) v = v | (32'(m_en_prog[i]) << i);
        end else if (off == PW + 2) begin
            v = 32'(m_pend);
        end else if (off >= PW + 3) begin
            v = m_cnt[off - PW - 3];
        end
        return v;
    endfunction

    function automatic bit lane(input logic [3:0] b, input int k);
        return 1'((b >> k));
    endfunction

    function automatic void model_update(input logic [7:0] a, input logic w, input logic [31:0] d,
                                         input logic [3:0] b, input logic v, input logic [N-1:0] g,
                                         input logic id);
        int off;
        bit commit, clr, copied;
        commit = 0; clr = 0; copied = 0;
        off = int'(a) - BASE;
        if (SHADOW && m_pend && id) begin
            for (int i = 0; i < N; i++) begin
                m_prio_live[i] = m_prio_prog[i];
                m_en_live[i]   = m_en_prog[i];
            end
            m_pend = 0; copied = 1;
        end
        if (w && off >= 0 && off < WIN) begin
            if (off < PW) begin
                for (int j = 0; j < 8; j++)
                    if (off * 8 + j < N && lane(b, j / 2)) m_prio_prog[off * 8 + j] = 4'(d >> (j * 4));
            end else if (off == PW) begin
                for (int i = 0; i < N; i++)
                    if (lane(b, i / 8)) m_en_prog[i] = 1'(d >> i);
            end else if (off == PW + 1 && lane(b, 0)) begin
                commit = 1'(d);
                clr    = 1'(d >> 1);
            end
        end
        if (SHADOW && commit && !copied) m_pend = 1;
        if (!SHADOW) begin
            for (int i = 0; i < N; i++) begin
                m_prio_live[i] = m_prio_prog[i];
                m_en_live[i]   = m_en_prog[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (clr) m_cnt[i] = 32'h0;
            else if (v && 1'(g >> i) && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
        end
    endfunction

    function automatic logic [N*4-1:0] model_prio();
        logic [N*4-1:0] v = '0;
        for (int i = 0; i < N; i++) v = v | ((N*4)'(m_prio_live[i]) << (i * 4));
        return v;
    endfunction

    function automatic logic [N-1:0] model_en();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v = v | (N'(m_en_live[i]) << i);
        return v;
    endfunction

    // One bus cycle: drive at negedge, step the model, return #1 after the edge.
    task automatic cycle(input logic [7:0] a, input logic r, input logic w, input logic [31:0] d,
                         input logic [3:0] b, input logic v, input logic [N-1:0] g, input logic id);
        @(negedge clk);
        addr = a; rd = r; wr = w; wd = d; be = b; gv = v; grant = g; idle = id;
        exp_rv = r;
        exp_rd = r ? model_read(a) : 32'h0;
        model_update(a, w, d, b, v, g, id);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"}, 64'(rvalid), 64'(exp_rv));
        chk({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
        chk({tag, "_prio"},  64'(cfg_prio), 64'(model_prio()));
        chk({tag, "_en"},    64'(cfg_en), 64'(model_en()));
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        exp_rv;
        logic [31:0] exp_rdata;
        logic [15:0] exp_prio;
        logic [3:0]  exp_en;
    } vec_t;

    vec_t tbl[13];
    logic [N*4-1:0] prio_before;

    initial begin
        rst = 1'b1; addr = '0; rd = 0; wr = 0; wd = '0; be = '0; gv = 0; grant = '0; idle = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rvalid), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        chk("rst_prio",  64'(cfg_prio), 64'h0);
        chk("rst_en",    64'(cfg_en), 64'hF);
        @(negedge clk);
        rst = 1'b0;

        tbl[0]  = '{8'h00, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h0,  16'h0000, 4'hF};
        tbl[1]  = '{8'h01, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'hF,  16'h0000, 4'hF};
        tbl[2]  = '{8'h02, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h0,  16'h0000, 4'hF};
        tbl[3]  = '{8'h03, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h0,  16'h0000, 4'hF};
        tbl[4]  = '{8'h04, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h0,  16'h0000, 4'hF};
        tbl[5]  = '{8'h05, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h0,  16'h0000, 4'hF};
        tbl[6]  = '{8'h06, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h0,  16'h0000, 4'hF};
        tbl[7]  = '{8'h07, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h0,  16'h0000, 4'hF};
        tbl[8]  = '{8'h00, 1'b0, 1'b1, 32'h4321, 4'h1, 1'b0, 32'h0,  16'h0021, 4'hF};
        tbl[9]  = '{8'h00, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h21, 16'h0021, 4'hF};
        tbl[10] = '{8'h40, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 16'h0021, 4'hF};
        tbl[11] = '{8'h00, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'h21, 16'h0021, 4'hF};
        tbl[12] = '{8'h01, 1'b1, 1'b0, 32'h0,    4'h0, 1'b1, 32'hF,  16'h0021, 4'hF};

        if (!SHADOW) begin
            for (int k = 0; k < 13; k++) begin
                cycle(tbl[k].addr, tbl[k].rd, tbl[k].wr, tbl[k].wd, tbl[k].be, 1'b0, '0, 1'b0);
                chk($sformatf("tbl%0d_valid", k), 64'(rvalid), 64'(tbl[k].exp_rv));
                chk($sformatf("tbl%0d_rdata", k), 64'(rdata), 64'(tbl[k].exp_rdata));
                chk($sformatf("tbl%0d_prio", k),  64'(cfg_prio), 64'(tbl[k].exp_prio));
                chk($sformatf("tbl%0d_en", k),    64'(cfg_en), 64'(tbl[k].exp_en));
            end
        end

        // Grant counting, then clear colliding with a grant.
        for (int k = 0; k < 5; k++) cycle(8'h00, 1'b0, 1'b0, '0, '0, 1'b1, N'(4'b0100), 1'b0);
        cycle(8'h06, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk("cnt2_five", 64'(rdata), 64'd5);
        cycle(8'h02, 1'b0, 1'b1, 32'h2, 4'h1, 1'b1, N'(4'b0100), 1'b0);
        cycle(8'h06, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk("cnt2_cleared", 64'(rdata), 64'd0);

        // Saturation from near the top.
        @(negedge clk);
        force dut.gen_cnt[0].u_cnt.cnt_q = 32'hFFFF_FFFE;
        cycle(8'h00, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        release dut.gen_cnt[0].u_cnt.cnt_q;
        m_cnt[0] = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) cycle(8'h00, 1'b0, 1'b0, '0, '0, 1'b1, N'(4'b0001), 1'b0);
        cycle(8'h04, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk("cnt0_saturated", 64'(rdata), 64'hFFFF_FFFF);

`ifdef IGR_ARB_CSR_SHADOW_EN
        prio_before = model_prio();
        cycle(8'h00, 1'b0, 1'b1, 32'h5678, 4'hF, 1'b0, '0, 1'b0);
        cycle(8'h02, 1'b0, 1'b1, 32'h1, 4'h1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(8'h03, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
            chk("shadow_hold_prio", 64'(cfg_prio), 64'(prio_before));
            chk("shadow_pending", 64'(rdata), 64'd1);
        end
        cycle(8'h03, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        chk("shadow_commit_prio", 64'(cfg_prio), 64'h5678);
        cycle(8'h03, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk("shadow_status_clr", 64'(rdata), 64'd0);
`endif

        for (int k = 0; k < 400; k++) begin
            logic [7:0]  a;
            logic [31:0] d;
            int          r;
            logic        w;
            r = $urandom_range(0, 15);
            a = (r == 15) ? 8'h40 : 8'($urandom_range(0, WIN - 1));
            w = ($urandom_range(0, 3) == 0);
            d = $urandom;
            if (int'(a) == PW + 1 && $urandom_range(0, 7) != 0) d = d & ~32'h2;
            cycle(a, 1'($urandom), w, d, 4'($urandom), 1'($urandom), N'($urandom), 1'($urandom));
            chk_model("rand");
        end

        // Reset landing on an outstanding read response.
        cycle(8'h01, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk("pre_rst_valid", 64'(rvalid), 64'h1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_valid", 64'(rvalid), 64'h0);
        chk("mid_rst_rdata", 64'(rdata), 64'h0);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(8'h00, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk_model("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
